instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
Writer side of the instruction memory. The CPU fetch stage only reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake: a 16-bit word-count header, then the program words.
- Assembles each pair of bytes into a 16-bit instruction and writes it into the instruction memory write port at byte addresses stepping by 2, matching the PC increment.
- Holds the CPU's PC (pc_stop) until a load completes.

Parameters:
MEM_WORDS, 256, capacity of instruction memory in 16-bit words; headers larger than this are rejected.
BASE_ADDR, 16'h0000, byte address of the first loaded word.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader can accept a byte this cycle.
im_write_enable  output  1  one-cycle write strobe to instruction memory.
im_address  output  16  byte address of the word being written.
im_write_data  output  16  instruction word being written.
cpu_hold  output  1  drives pc_stop; high while no completed load exists.
load_done  output  1  high in DONE.
load_error  output  1  header exceeded MEM_WORDS; valid in DONE.
words_loaded  output  16  count of words written in the current or last load.

Behaviour:
- Handshake: a byte is consumed on a rising clock edge where in_valid and in_ready are both 1. in_data is sampled only on that edge. in_valid may drop at any time without loss.
- All outputs are registered.
- in_ready is 1 only in LEN_HI, LEN_LO, DATA_HI and DATA_LO.
- cpu_hold is 1 in every state except DONE.
- Reset values: state IDLE, in_ready 0, im_write_enable 0, im_address BASE_ADDR, im_write_data 0, cpu_hold 1, load_done 0, load_error 0, words_loaded 0, internal count 0.
- IDLE:
  - start -> LEN_HI.
  - Clears words_loaded and load_error; im_address = BASE_ADDR.
- LEN_HI: accepted byte -> count[15:8]; go to LEN_LO.
- LEN_LO: accepted byte -> count[7:0]; then check the full count:
  - count == 0 -> DONE, load_error 0.
  - count > MEM_WORDS -> DONE, load_error 1, no memory writes.
  - otherwise -> DATA_HI.
- DATA_HI: accepted byte -> word[15:8]; go to DATA_LO.
- DATA_LO: accepted byte -> word[7:0]; go to WRITE.
- WRITE (exactly one cycle):
  - im_write_enable = 1, im_write_data = assembled word, im_address = BASE_ADDR + 2*words_loaded (16-bit wrap).
  - On exit, words_loaded increments.
  - If the new words_loaded equals count -> DONE, else -> DATA_HI.
- DONE:
  - load_done 1, cpu_hold 0.
  - Stays until reset, or until start, which behaves as in IDLE (reload: clears flags, reasserts cpu_hold, -> LEN_HI).
- Latency and throughput:
  - im_write_enable rises the cycle after the edge that accepted the low byte.
  - With in_valid held at 1, one word takes 3 cycles (hi, lo, write).
  - cpu_hold falls the cycle after the final WRITE.
- start is ignored in LEN_HI through WRITE.
- Simultaneous start and byte acceptance cannot occur, because in_ready is 0 in IDLE and DONE.
- Bytes in the stream beyond count words are not consumed: in_ready is 0 in DONE.
- Reset mid-load:
  - Immediate return to reset values.
  - Memory already written is left unchanged.
  - cpu_hold is 1 again.
- im_write_enable is never high for two consecutive cycles.

Test Plan:
1. Reset -> cpu_hold 1, in_ready 0, im_write_enable 0, im_address 0, load_done 0. Assert reset mid-DATA_LO -> same values within the cycle, no write strobe.
2. Start; stream 00 02 12 34 AB CD with in_valid held at 1 -> two writes:
   - 16'h1234 at address 0x0000, then 16'hABCD at 0x0002, three cycles apart.
   - Then load_done 1, cpu_hold 0, words_loaded 2.
3. Same stream with in_valid toggling 1,0,0,1 between bytes -> identical writes and values, no duplicate or dropped bytes; in_ready stays 1 while waiting in a data state.
4. Header 00 00 -> DONE after the LEN_LO accept, words_loaded 0, load_error 0, no writes. Header 01 01 (257 > 256) -> DONE with load_error 1, no writes.
5. start pulsed during DATA_HI -> ignored, load completes normally. In DONE, pulse start with header 00 01, word 5A5A -> cpu_hold 1 again, then one write at 0x0000, load_done 1.
6. BASE_ADDR = 16'h0100 with header 00 03 -> writes at 0x0100, 0x0102 and 0x0104.

Source files
------------

// File: rtl/instruction_loader.sv
// Loads a byte-streamed program (16-bit word count header, then words) into
// instruction memory and holds the CPU's PC until a complete load exists.
module instruction_loader #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        im_write_enable,
    output logic [15:0] im_address,
    output logic [15:0] im_write_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam int unsigned CNT_W = 17;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] count;
    logic [7:0]  word_hi;

    logic        accept;
    logic [15:0] len_full;
    logic [15:0] next_loaded;

    assign accept      = in_valid & in_ready;
    assign len_full    = {count[15:8], in_data};
    assign next_loaded = words_loaded + 16'd1;

    // Every output is a register updated alongside the state it belongs to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            count           <= 16'd0;
            word_hi         <= 8'd0;
            in_ready        <= 1'b0;
            im_write_enable <= 1'b0;
            im_address      <= BASE_ADDR;
            im_write_data   <= 16'd0;
            cpu_hold        <= 1'b1;
            load_done       <= 1'b0;
            load_error      <= 1'b0;
            words_loaded    <= 16'd0;
        end else begin
            im_write_enable <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= LEN_HI;
                        in_ready     <= 1'b1;
                        cpu_hold     <= 1'b1;
                        load_done    <= 1'b0;
                        load_error   <= 1'b0;
                        words_loaded <= 16'd0;
                        im_address   <= BASE_ADDR;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        count[15:8] <= in_data;
                        state       <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        count <= len_full;
                        if (len_full == 16'd0 || {1'b0, len_full} > MAX_WORDS) begin
                            // Empty or oversized program: finish without touching memory.
                            state      <= DONE;
                            in_ready   <= 1'b0;
                            cpu_hold   <= 1'b0;
                            load_done  <= 1'b1;
                            load_error <= (len_full != 16'd0);
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (accept) begin
                        word_hi <= in_data;
                        state   <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (accept) begin
                        im_write_data   <= {word_hi, in_data};
                        im_address      <= BASE_ADDR + {words_loaded[14:0], 1'b0};
                        im_write_enable <= 1'b1;
                        in_ready        <= 1'b0;
                        state           <= WRITE;
                    end
                end
                WRITE: begin
                    words_loaded <= next_loaded;
                    if (next_loaded == count) begin
                        state     <= DONE;
                        cpu_hold  <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        state    <= DATA_HI;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized scoreboard bench for instruction_loader: two instances (base 0x0000
// and 0x0100) share one byte stream; a monitor checks every memory write.
module tb_instruction_loader;

    typedef struct packed {
        logic [15:0] off;
        logic [15:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;

    logic        ra, wea, ha, doa, ea;
    logic [15:0] aa, da, wla;
    logic        rb, web, hb, dob, eb;
    logic [15:0] ab, db, wlb;

    exp_t        qa[$];
    exp_t        qb[$];
    int          wcyc[$];
    logic [15:0] wq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        prev_wea = 1'b0;
    logic        prev_web = 1'b0;

    always #5 clock = ~clock;

    instruction_loader #(.MEM_WORDS(256), .BASE_ADDR(16'h0000)) dut_a (
        .clock(clock), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ra), .im_write_enable(wea), .im_address(aa), .im_write_data(da),
        .cpu_hold(ha), .load_done(doa), .load_error(ea), .words_loaded(wla));

    instruction_loader #(.MEM_WORDS(256), .BASE_ADDR(16'h0100)) dut_b (
        .clock(clock), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rb), .im_write_enable(web), .im_address(ab), .im_write_data(db),
        .cpu_hold(hb), .load_done(dob), .load_error(eb), .words_loaded(wlb));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop the expected write whenever a DUT strobes its write port.
    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (wea) begin
            chk("we_back_to_back_a", 32'(prev_wea), 32'd0);
            if (qa.size() == 0) chk("unexpected_write_a", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                chk("addr_a", 32'(aa), 32'(16'h0000 + e.off));
                chk("data_a", 32'(da), 32'(e.data));
                wcyc.push_back(cyc);
            end
        end
        if (web) begin
            chk("we_back_to_back_b", 32'(prev_web), 32'd0);
            if (qb.size() == 0) chk("unexpected_write_b", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                chk("addr_b", 32'(ab), 32'(16'h0100 + e.off));
                chk("data_b", 32'(db), 32'(e.data));
            end
        end
        prev_wea = wea;
        prev_web = web;
    end

    task automatic check_reset_vals();
        chk("rst_ready_a", 32'(ra), 0);  chk("rst_ready_b", 32'(rb), 0);
        chk("rst_we_a", 32'(wea), 0);    chk("rst_we_b", 32'(web), 0);
        chk("rst_addr_a", 32'(aa), 32'h0000); chk("rst_addr_b", 32'(ab), 32'h0100);
        chk("rst_data_a", 32'(da), 0);
        chk("rst_hold_a", 32'(ha), 1);   chk("rst_hold_b", 32'(hb), 1);
        chk("rst_done_a", 32'(doa), 0);  chk("rst_err_a", 32'(ea), 0);
        chk("rst_words_a", 32'(wla), 0);
    endtask

    task automatic do_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        chk("start_hold", 32'(ha), 1);
        chk("start_done", 32'(doa), 0);
        chk("start_ready", 32'(ra), 1);
        chk("start_words", 32'(wla), 0);
        chk("start_err", 32'(ea), 0);
    endtask

    // Offers one byte after 'gap' idle cycles; optionally pulses start first.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        int waited;
        if (poke) begin
            @(negedge clock); in_valid = 1'b0; start = 1'b1;
            @(negedge clock); start = 1'b0;
            chk("poke_ready", 32'(ra), 1);
            chk("poke_done", 32'(doa), 0);
        end
        for (int i = 0; i < gap; i++) begin
            @(negedge clock);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            if (i >= 1) chk("ready_while_waiting", 32'(ra), 1);
        end
        waited = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        while (!ra && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!ra) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 2;
        return int'($urandom_range(3, 0));
    endfunction

    // Reference: a valid header n writes wq[0..n-1] at offsets 0,2,4...; otherwise nothing.
    task automatic run_load(input logic [15:0] n, input int mode, input bit poke);
        bit valid_len;
        int waited;
        valid_len = (n != 16'd0) && (int'(n) <= 256);
        do_start();
        wcyc.delete();
        if (valid_len)
            for (int i = 0; i < int'(n); i++) begin
                qa.push_back({16'(2 * i), wq[i]});
                qb.push_back({16'(2 * i), wq[i]});
            end
        send_byte(n[15:8], pick_gap(mode), 1'b0);
        send_byte(n[7:0], pick_gap(mode), 1'b0);
        if (valid_len)
            for (int i = 0; i < int'(n); i++) begin
                send_byte(wq[i][15:8], pick_gap(mode), poke && i == 0);
                send_byte(wq[i][7:0], pick_gap(mode), 1'b0);
            end
        @(negedge clock); in_valid = 1'b0;
        waited = 0;
        while (!doa && waited < 60) begin
            @(negedge clock);
            waited++;
        end
        chk("done_a", 32'(doa), 1);      chk("done_b", 32'(dob), 1);
        chk("hold_released_a", 32'(ha), 0); chk("hold_released_b", 32'(hb), 0);
        chk("ready_in_done", 32'(ra), 0);
        chk("error_a", 32'(ea), 32'(int'(n) > 256));
        chk("error_b", 32'(eb), 32'(int'(n) > 256));
        chk("words_a", 32'(wla), valid_len ? 32'(n) : 32'd0);
        chk("words_b", 32'(wlb), valid_len ? 32'(n) : 32'd0);
        chk("pending_a", 32'(qa.size()), 0);
        chk("pending_b", 32'(qb.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clock);
        check_reset_vals();
        reset = 1'b0;

        // Reset while waiting in DATA_LO: no write, back to reset values.
        do_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        @(negedge clock); in_valid = 1'b0;
        reset = 1'b1;
        #1 check_reset_vals();
        @(negedge clock); reset = 1'b0;
        @(negedge clock);

        // Gapless two-word load; writes three cycles apart.
        wq = '{16'h1234, 16'hABCD};
        run_load(16'd2, 0, 1'b0);
        if (wcyc.size() == 2) chk("write_spacing", 32'(wcyc[1] - wcyc[0]), 32'd3);
        else chk("write_count", 32'(wcyc.size()), 32'd2);

        // Same stream with two idle cycles before each byte.
        run_load(16'd2, 1, 1'b0);

        // Empty and oversized headers.
        run_load(16'd0, 0, 1'b0);
        run_load(16'h0101, 2, 1'b0);

        // start during DATA_HI is ignored; then reload from DONE.
        wq = '{16'hBEEF, 16'h0F0F};
        run_load(16'd2, 0, 1'b1);
        wq = '{16'h5A5A};
        run_load(16'd1, 0, 1'b0);

        // Three-word load (0x0100/0x0102/0x0104 on the offset instance).
        wq = '{16'h1111, 16'h2222, 16'h3333};
        run_load(16'd3, 0, 1'b0);

        // Randomized programs and gaps.
        for (int k = 0; k < 6; k++) begin
            int n;
            n = int'($urandom_range(10, 1));
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
            run_load(16'(n), 2, 1'b0);
        end

        // Capacity boundary: exactly MEM_WORDS words, last one at 0x01FE.
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back(16'($urandom));
        run_load(16'd256, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
